sram_async_ctrl: RTL and testbench
==================================

// Module: sram_async_ctrl
// PURPOSE
//  Parametrised request/ack controller for asynchronous SRAM (IS61LV-class), the next generation of our
//  single-chip read/write controller. Adds explicit read requests, per-byte write enables and registered
//  read data with a valid strobe. Adds programmable setup/pulse/hold/read wait counts and glitch-free
//  registered SRAM control pins. Sits between the video/mouse logic and the board SRAM pins.
// PARAMETERS
//  ADDR_W    18  SRAM address width
//  DATA_W    16  data width; multiple of 8
//  BE_W      DATA_W/8  byte-lane count (derived, not overridden)
//  WR_SETUP  1   cycles address+data stable before WEN falls (>=1)
//  WR_PULSE  1   cycles WEN held low (>=1)
//  WR_HOLD   1   cycles data held after WEN rises (>=1)
//  RD_WAIT   1   cycles OEN low before RDATA is sampled (>=1)
// PORTS
//  CLK        in   1       system clock
//  RESET      in   1       synchronous, active-high reset
//  REQ        in   1       request; accepted on a CLK edge where REQ & READY
//  WE         in   1       1 = write, 0 = read; sampled with REQ
//  ADDR       in   ADDR_W  word address; sampled with REQ
//  WDATA      in   DATA_W  write data; sampled with REQ
//  BE         in   BE_W    byte enables, active-high; sampled with REQ (reads use all lanes)
//  READY      out  1       controller idle; a request can be accepted
//  RDATA      out  DATA_W  read data register; holds last read value
//  RVALID     out  1       1-cycle pulse: RDATA updated
//  WDONE      out  1       1-cycle pulse: write cycle finished
//  SRAM_ADDR  out  ADDR_W  SRAM address pins
//  SRAM_DQ    io   DATA_W  SRAM data pins; hi-Z except during write states
//  SRAM_CEN / SRAM_OEN / SRAM_WEN  out 1 each  active-low chip/output/write enable
//  SRAM_BEN   out  BE_W    active-low byte enables (LB/UB for 16 bits)
// BEHAVIOUR
//  - Reset (held or on any edge with RESET=1): state IDLE; READY=0 while RESET, 1 on the first cycle after;
//    SRAM_CEN/OEN/WEN=1, SRAM_BEN all 1, SRAM_DQ hi-Z, RVALID=WDONE=0, RDATA=0, SRAM_ADDR=0.
//  - All SRAM_* control/address pins and the DQ output-enable are flops loaded with the values of the
//    next state; no combinational path from any input to an SRAM pin.
//  - States: IDLE, RD, WR_SU, WR_PW, WR_HD. A single down-counter cnt is loaded on every state entry.
//  - IDLE: CEN=OEN=WEN=1, DQ hi-Z, READY=1. REQ&~WE -> RD (cnt=RD_WAIT-1); REQ&WE -> WR_SU (cnt=WR_SETUP-1).
//    ADDR/WDATA/BE are latched at acceptance; later input changes have no effect on the transfer.
//  - RD: CEN=0, OEN=0, BEN=0. When cnt==0: RDATA<=SRAM_DQ, RVALID=1 next cycle, -> IDLE.
//    Latency: accept edge to RVALID high = RD_WAIT+1 cycles.
//  - WR_SU: CEN=0, OEN=1, WEN=1, DQ driven, BEN=~BE_latched; cnt==0 -> WR_PW (cnt=WR_PULSE-1).
//  - WR_PW: as WR_SU but WEN=0; cnt==0 -> WR_HD (cnt=WR_HOLD-1).
//  - WR_HD: WEN=1, DQ still driven; cnt==0 -> IDLE with WDONE=1 in that IDLE cycle.
//    Write occupancy: WR_SETUP+WR_PULSE+WR_HOLD cycles.
//  - OEN and WEN are never low in the same cycle. DQ is never driven while OEN=0.
//  - BE==0 on a write: full timing still runs with all BEN high (no lanes written); WDONE still pulses.
//  - REQ while READY=0: ignored, not queued. The caller holds REQ until it sees READY.
//  - Back-to-back: REQ may be accepted in the same IDLE cycle in which RVALID/WDONE is high.
//    Minimum one IDLE cycle between transfers, giving bus turnaround.
//  - RESET mid-transfer: next edge forces reset values; WEN/OEN rise and DQ goes hi-Z.
//    No RVALID/WDONE is issued; the contents of an interrupted write address are undefined.
//  - Address width: ADDR_W bits pass through unchanged; no wrap or range checking.
// STRUCTURE
//  - sram_ctrl_pkg: state encoding localparams (IDLE, RD, WR_SU, WR_PW, WR_HD) and default timing constants.
//  - Sub-module sram_wait_timer: loadable down-counter, width $clog2(max count)+1, outputs zero flag.
//  - Elaboration check: error if any timing param < 1 or DATA_W % 8 != 0.
// TESTING
//  1 Reset: RESET=1 for 3 cycles -> CEN/OEN/WEN=1, BEN=2'b11, DQ hi-Z, READY=0; READY=1 the cycle after release.
//  2 Write 0x1234 @0x00055, BE=2'b11, defaults -> WEN low exactly 1 cycle, DQ=0x1234 for 3 cycles, WDONE 3 cycles after accept.
//  3 Read @0x00055 with SRAM model -> RVALID 2 cycles after accept, RDATA=0x1234; OEN never low while DQ driven.
//  4 Write 0xAB00 @0x3FFFF, BE=2'b10, WR_PULSE=3 -> BEN=2'b01, WEN low 3 cycles; read-back gives 0xAB in the upper byte, old lower byte.
//  5 REQ held while busy plus changed ADDR/WDATA mid-write -> second request taken only after READY; first write data is unchanged.
//  6 RESET asserted during WR_PW -> WEN=1 and DQ hi-Z on the next edge; no WDONE; READY returns after reset.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared state encoding, default timing and sizing helpers for the async SRAM controller.
package sram_ctrl_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RD    = 3'd1;
  localparam logic [2:0] ST_WR_SU = 3'd2;
  localparam logic [2:0] ST_WR_PW = 3'd3;
  localparam logic [2:0] ST_WR_HD = 3'd4;

  localparam int DEF_ADDR_W   = 18;
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_WR_SETUP = 1;
  localparam int DEF_WR_PULSE = 1;
  localparam int DEF_WR_HOLD  = 1;
  localparam int DEF_RD_WAIT  = 1;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One spare bit keeps the counter wide enough even when every count is 1.
  function automatic int timer_width(input int max_cnt);
    return $clog2(max_cnt) + 1;
  endfunction

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable down-counter that parks at zero; o_zero marks the last cycle of a timed phase.
module sram_wait_timer #(
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // Count down from the loaded value and hold at zero
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {W{1'b0}}) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_zero = (r_cnt == {W{1'b0}});

endmodule

// File: rtl/sram_async_ctrl.sv
// Request/ack controller for asynchronous SRAM with programmable setup/pulse/hold/read timing.
// Every SRAM pin is a flop loaded with the value belonging to the next state.
module sram_async_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  localparam int BE_W    = DATA_W / 8,
  parameter int WR_SETUP = DEF_WR_SETUP,
  parameter int WR_PULSE = DEF_WR_PULSE,
  parameter int WR_HOLD  = DEF_WR_HOLD,
  parameter int RD_WAIT  = DEF_RD_WAIT
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rvalid,
  output logic              o_wdone,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [DATA_W-1:0] io_sram_dq,
  output logic              o_sram_cen,
  output logic              o_sram_oen,
  output logic              o_sram_wen,
  output logic [BE_W-1:0]   o_sram_ben
);

  if (WR_SETUP < 1 || WR_PULSE < 1 || WR_HOLD < 1 || RD_WAIT < 1 || (DATA_W % 8) != 0) begin : g_param_check
    $error("sram_async_ctrl: timing parameters must be >= 1 and DATA_W a multiple of 8");
  end

  localparam int CNT_W = timer_width(max_of4(WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT));
  localparam logic [CNT_W-1:0] LD_RD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] LD_SU = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_PW = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_HD = CNT_W'(WR_HOLD - 1);

  logic [2:0]        r_state, w_state_nxt;
  logic              w_load, w_zero, w_accept;
  logic [CNT_W-1:0]  w_load_val;
  logic [BE_W-1:0]   w_be_nxt, w_ben_nxt;
  logic              w_cen_nxt, w_oen_nxt, w_wen_nxt, w_dq_oe_nxt;
  logic              r_ready, r_cen, r_oen, r_wen, r_dq_oe;
  logic [BE_W-1:0]   r_ben, r_be;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_dq_out, r_rd_cap, r_rdata;
  logic              r_rd_pend, r_rvalid, r_wdone;

  assign w_accept = i_req & r_ready & (r_state == ST_IDLE);

  sram_wait_timer #(.W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_zero     (w_zero)
  );

  // State register and all SRAM-facing flops
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_cen   <= 1'b1;
      r_oen   <= 1'b1;
      r_wen   <= 1'b1;
      r_ben   <= {BE_W{1'b1}};
      r_dq_oe <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == ST_IDLE);
      r_cen   <= w_cen_nxt;
      r_oen   <= w_oen_nxt;
      r_wen   <= w_wen_nxt;
      r_ben   <= w_ben_nxt;
      r_dq_oe <= w_dq_oe_nxt;
    end
  end

  // Next-state logic; the timer is reloaded on every state entry
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_val  = {CNT_W{1'b0}};
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = i_we ? ST_WR_SU : ST_RD;
          w_load_val  = i_we ? LD_SU : LD_RD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_RD;
        end
      end
      ST_WR_SU: begin
        if (w_zero) begin
          w_state_nxt = ST_WR_PW;
          w_load      = 1'b1;
          w_load_val  = LD_PW;
        end else begin
          w_state_nxt = ST_WR_SU;
        end
      end
      ST_WR_PW: begin
        if (w_zero) begin
          w_state_nxt = ST_WR_HD;
          w_load      = 1'b1;
          w_load_val  = LD_HD;
        end else begin
          w_state_nxt = ST_WR_PW;
        end
      end
      ST_WR_HD: begin
        if (w_zero) begin
          w_state_nxt = ST_IDLE;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_WR_HD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_load      = 1'b1;
      end
    endcase
  end

  // Pin values for the state about to be entered; byte lanes come from the request on acceptance
  always_comb begin
    w_be_nxt    = w_accept ? i_be : r_be;
    w_cen_nxt   = 1'b1;
    w_oen_nxt   = 1'b1;
    w_wen_nxt   = 1'b1;
    w_dq_oe_nxt = 1'b0;
    w_ben_nxt   = {BE_W{1'b1}};
    case (w_state_nxt)
      ST_IDLE: begin
        w_cen_nxt = 1'b1;
      end
      ST_RD: begin
        w_cen_nxt = 1'b0;
        w_oen_nxt = 1'b0;
        w_ben_nxt = {BE_W{1'b0}};
      end
      ST_WR_SU, ST_WR_HD: begin
        w_cen_nxt   = 1'b0;
        w_dq_oe_nxt = 1'b1;
        w_ben_nxt   = ~w_be_nxt;
      end
      ST_WR_PW: begin
        w_cen_nxt   = 1'b0;
        w_wen_nxt   = 1'b0;
        w_dq_oe_nxt = 1'b1;
        w_ben_nxt   = ~w_be_nxt;
      end
      default: begin
        w_cen_nxt = 1'b1;
      end
    endcase
  end

  // Request latches, read capture and completion strobes
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr    <= {ADDR_W{1'b0}};
      r_dq_out  <= {DATA_W{1'b0}};
      r_be      <= {BE_W{1'b0}};
      r_rd_cap  <= {DATA_W{1'b0}};
      r_rd_pend <= 1'b0;
      r_rdata   <= {DATA_W{1'b0}};
      r_rvalid  <= 1'b0;
      r_wdone   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= i_addr;
        r_dq_out <= i_wdata;
        r_be     <= i_be;
      end
      if ((r_state == ST_RD) && w_zero) begin
        r_rd_cap <= io_sram_dq;
      end
      r_rd_pend <= (r_state == ST_RD) && w_zero;
      if (r_rd_pend) begin
        r_rdata <= r_rd_cap;
      end
      r_rvalid <= r_rd_pend;
      r_wdone  <= (r_state == ST_WR_HD) && w_zero;
    end
  end

  assign io_sram_dq  = r_dq_oe ? r_dq_out : {DATA_W{1'bz}};
  assign o_ready     = r_ready;
  assign o_rdata     = r_rdata;
  assign o_rvalid    = r_rvalid;
  assign o_wdone     = r_wdone;
  assign o_sram_addr = r_addr;
  assign o_sram_cen  = r_cen;
  assign o_sram_oen  = r_oen;
  assign o_sram_wen  = r_wen;
  assign o_sram_ben  = r_ben;

endmodule

// File: tb/tb_sram_async_ctrl.sv
// Directed bench for sram_async_ctrl: a default-timing instance and a WR_PULSE=3 instance,
// each on its own SRAM model; a keeper pattern on the idle bus exposes any stray DQ drive.
module tb_sram_async_ctrl;

  localparam logic [15:0] KEEP = 16'h5AC3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [17:0] addr  [2];
  logic [15:0] wdata [2];
  logic [1:0]  be    [2];

  wire  [1:0]  ready, rvalid, wdone, cen, oen, wen;
  wire  [15:0] rdata [2];
  wire  [17:0] saddr [2];
  wire  [1:0]  ben   [2];
  wire  [15:0] dq0, dq1;
  wire  [15:0] dq    [2];

  logic [15:0] mem0 [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
  logic [15:0] mem1 [4] = '{16'h0000, 16'h0000, 16'h0000, 16'h5566};

  int checks  = 0;
  int errors  = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  sram_async_ctrl u_dut0 (
    .i_clk(clk), .i_reset(rst), .i_req(req[0]), .i_we(we[0]), .i_addr(addr[0]),
    .i_wdata(wdata[0]), .i_be(be[0]), .o_ready(ready[0]), .o_rdata(rdata[0]),
    .o_rvalid(rvalid[0]), .o_wdone(wdone[0]), .o_sram_addr(saddr[0]), .io_sram_dq(dq0),
    .o_sram_cen(cen[0]), .o_sram_oen(oen[0]), .o_sram_wen(wen[0]), .o_sram_ben(ben[0])
  );

  sram_async_ctrl #(.WR_PULSE(3)) u_dut1 (
    .i_clk(clk), .i_reset(rst), .i_req(req[1]), .i_we(we[1]), .i_addr(addr[1]),
    .i_wdata(wdata[1]), .i_be(be[1]), .o_ready(ready[1]), .o_rdata(rdata[1]),
    .o_rvalid(rvalid[1]), .o_wdone(wdone[1]), .o_sram_addr(saddr[1]), .io_sram_dq(dq1),
    .o_sram_cen(cen[1]), .o_sram_oen(oen[1]), .o_sram_wen(wen[1]), .o_sram_ben(ben[1])
  );

  // SRAM models: drive on a read, keeper pattern while deselected, released otherwise
  assign dq0 = cen[0] ? KEEP : ((!oen[0] && wen[0]) ? mem0[saddr[0][1:0]] : 16'hzzzz);
  assign dq1 = cen[1] ? KEEP : ((!oen[1] && wen[1]) ? mem1[saddr[1][1:0]] : 16'hzzzz);
  assign dq[0] = dq0;
  assign dq[1] = dq1;

  always @(posedge clk) begin
    if (!cen[0] && !wen[0]) begin
      if (!ben[0][0]) mem0[saddr[0][1:0]][7:0]  <= dq0[7:0];
      if (!ben[0][1]) mem0[saddr[0][1:0]][15:8] <= dq0[15:8];
    end
    if (!cen[1] && !wen[1]) begin
      if (!ben[1][0]) mem1[saddr[1][1:0]][7:0]  <= dq1[7:0];
      if (!ben[1][1]) mem1[saddr[1][1:0]][15:8] <= dq1[15:8];
    end
  end

  always @(negedge clk) begin
    if ((oen[0] === 1'b0 && wen[0] === 1'b0) || (oen[1] === 1'b0 && wen[1] === 1'b0))
      overlap <= overlap + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int d, input logic w, input logic [17:0] a,
                       input logic [15:0] dt, input logic [1:0] b);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = dt; be[d] = b;
    tick();
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({cen[0], oen[0], wen[0], ben[0], ready[0], rvalid[0], wdone[0]} !== 8'b111_11_000) begin
        errors++;
        $display("FAIL reset_pins c=%0d: got %b want 11111000", c,
                 {cen[0], oen[0], wen[0], ben[0], ready[0], rvalid[0], wdone[0]});
      end
      checks++;
      if (dq[0] !== KEEP) begin errors++; $display("FAIL reset_dq_hiz: got %h want %h", dq[0], KEEP); end
    end
    checks++;
    if (rdata[0] !== 16'h0000 || saddr[0] !== 18'h0) begin
      errors++; $display("FAIL reset_regs: rdata %h addr %h want 0", rdata[0], saddr[0]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready !== 2'b11) begin errors++; $display("FAIL reset_ready_after: got %b want 11", ready); end
  endtask

  task automatic test_write();
    checks++;
    if (ready[0] !== 1'b1) begin errors++; $display("FAIL wr_ready_pre: got %b want 1", ready[0]); end
    issue(0, 1'b1, 18'h00055, 16'h1234, 2'b11);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({cen[0], oen[0], wen[0]} !== {1'b0, 1'b1, (c == 1) ? 1'b0 : 1'b1}) begin
        errors++; $display("FAIL wr_ctl c=%0d: got %b", c, {cen[0], oen[0], wen[0]});
      end
      checks++;
      if (dq[0] !== 16'h1234 || ben[0] !== 2'b00 || saddr[0] !== 18'h00055 || wdone[0] !== 1'b0) begin
        errors++; $display("FAIL wr_bus c=%0d: dq %h ben %b addr %h wdone %b want 1234 00 00055 0",
                           c, dq[0], ben[0], saddr[0], wdone[0]);
      end
      tick();
    end
    checks++;
    if ({wdone[0], ready[0], cen[0]} !== 3'b111 || dq[0] !== KEEP) begin
      errors++; $display("FAIL wr_done: wdone/ready/cen %b dq %h want 111 %h",
                         {wdone[0], ready[0], cen[0]}, dq[0], KEEP);
    end
    tick();
    checks++;
    if (wdone[0] !== 1'b0) begin errors++; $display("FAIL wr_done_pulse: got %b want 0", wdone[0]); end
    checks++;
    if (mem0[1] !== 16'h1234) begin errors++; $display("FAIL wr_mem: got %h want 1234", mem0[1]); end
  endtask

  task automatic test_read();
    issue(0, 1'b0, 18'h00055, 16'hFFFF, 2'b00);
    checks++;
    if ({cen[0], oen[0], wen[0], ben[0], rvalid[0]} !== 6'b001_00_0) begin
      errors++; $display("FAIL rd_pins: got %b want 001000", {cen[0], oen[0], wen[0], ben[0], rvalid[0]});
    end
    tick();
    checks++;
    if (rvalid[0] !== 1'b0 || oen[0] !== 1'b1) begin
      errors++; $display("FAIL rd_early: rvalid %b oen %b want 0 1", rvalid[0], oen[0]);
    end
    tick();
    checks++;
    if (rvalid[0] !== 1'b1 || rdata[0] !== 16'h1234) begin
      errors++; $display("FAIL rd_data: rvalid %b rdata %h want 1 1234", rvalid[0], rdata[0]);
    end
    tick();
    checks++;
    if (rvalid[0] !== 1'b0 || rdata[0] !== 16'h1234) begin
      errors++; $display("FAIL rd_hold: rvalid %b rdata %h want 0 1234", rvalid[0], rdata[0]);
    end
  endtask

  task automatic test_be_zero();
    issue(0, 1'b1, 18'h00055, 16'hFFFF, 2'b00);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ben[0] !== 2'b11 || cen[0] !== 1'b0) begin
        errors++; $display("FAIL be0_ben c=%0d: ben %b cen %b want 11 0", c, ben[0], cen[0]);
      end
      tick();
    end
    checks++;
    if (wdone[0] !== 1'b1) begin errors++; $display("FAIL be0_wdone: got %b want 1", wdone[0]); end
    checks++;
    if (mem0[1] !== 16'h1234) begin errors++; $display("FAIL be0_mem: got %h want 1234", mem0[1]); end
    tick();
  endtask

  task automatic test_partial_write();
    issue(1, 1'b1, 18'h3FFFF, 16'hAB00, 2'b10);
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (wen[1] !== ((c >= 1 && c <= 3) ? 1'b0 : 1'b1) || ben[1] !== 2'b01 || dq[1] !== 16'hAB00) begin
        errors++; $display("FAIL pw_bus c=%0d: wen %b ben %b dq %h", c, wen[1], ben[1], dq[1]);
      end
      tick();
    end
    checks++;
    if (wdone[1] !== 1'b1) begin errors++; $display("FAIL pw_wdone: got %b want 1", wdone[1]); end
    tick();
    issue(1, 1'b0, 18'h3FFFF, 16'h0000, 2'b11);
    tick();
    tick();
    checks++;
    if (rvalid[1] !== 1'b1 || rdata[1] !== 16'hAB66) begin
      errors++; $display("FAIL pw_readback: rvalid %b rdata %h want 1 ab66", rvalid[1], rdata[1]);
    end
  endtask

  task automatic test_busy_hold();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 18'h00100; wdata[0] = 16'hBEEF; be[0] = 2'b11;
    tick();
    addr[0] = 18'h00202; wdata[0] = 16'hC0DE;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (ready[0] !== 1'b0 || saddr[0] !== 18'h00100 || dq[0] !== 16'hBEEF) begin
        errors++; $display("FAIL busy_first c=%0d: ready %b addr %h dq %h want 0 00100 beef",
                           c, ready[0], saddr[0], dq[0]);
      end
      tick();
    end
    checks++;
    if (wdone[0] !== 1'b1 || ready[0] !== 1'b1) begin
      errors++; $display("FAIL busy_idle: wdone %b ready %b want 1 1", wdone[0], ready[0]);
    end
    tick();
    req[0] = 1'b0;
    checks++;
    if (saddr[0] !== 18'h00202 || dq[0] !== 16'hC0DE || cen[0] !== 1'b0) begin
      errors++; $display("FAIL busy_second: addr %h dq %h cen %b want 00202 c0de 0", saddr[0], dq[0], cen[0]);
    end
    repeat (3) tick();
    checks++;
    if (wdone[0] !== 1'b1) begin errors++; $display("FAIL busy_wdone2: got %b want 1", wdone[0]); end
    checks++;
    if (mem0[0] !== 16'hBEEF || mem0[2] !== 16'hC0DE) begin
      errors++; $display("FAIL busy_mem: got %h %h want beef c0de", mem0[0], mem0[2]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    issue(0, 1'b1, 18'h00055, 16'h7777, 2'b11);
    tick();
    checks++;
    if (wen[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pw: wen %b want 0", wen[0]); end
    rst = 1'b1;
    tick();
    checks++;
    if ({wen[0], oen[0], cen[0], ready[0], wdone[0]} !== 5'b11100 || dq[0] !== KEEP) begin
      errors++; $display("FAIL rstmid_pins: wen/oen/cen/ready/wdone %b dq %h want 11100 %h",
                         {wen[0], oen[0], cen[0], ready[0], wdone[0]}, dq[0], KEEP);
    end
    tick();
    checks++;
    if (wdone[0] !== 1'b0 || rdata[0] !== 16'h0000) begin
      errors++; $display("FAIL rstmid_hold: wdone %b rdata %h want 0 0000", wdone[0], rdata[0]);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (ready[0] !== 1'b1 || wdone[0] !== 1'b0) begin
      errors++; $display("FAIL rstmid_after: ready %b wdone %b want 1 0", ready[0], wdone[0]);
    end
  endtask

  task automatic test_protocol();
    checks++;
    if (overlap !== 0) begin errors++; $display("FAIL oen_wen_overlap: got %0d cycles want 0", overlap); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 18'h0; wdata[i] = 16'h0; be[i] = 2'b00;
    end
    #2;
    test_reset();
    test_write();
    test_read();
    test_be_zero();
    test_partial_write();
    test_busy_hold();
    test_reset_mid();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
